// File: rtl/sha_round_sequencer_pkg.sv
// sha_pkg: shared state encoding, round limit and per-core nonce range helper
package sha_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, CHECK, DONE} state_e;
  localparam logic [5:0] LAST_ROUND = 6'd63;
  function automatic logic [31:0] range_for(input logic [31:0] ncore);
    return 32'hFFFF_FFFF / ncore;
  endfunction
endpackage

// File: rtl/sha_round_sequencer_counter.sv
// counter: clearable enabled up-counter that wraps to zero after rollover_val
module counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  // clear wins over enable; wrap happens after reaching rollover_val
  always_comb count_d = clear ? '0 : en ? (count_q == rollover_val ? '0 : count_q + W'(1)) : count_q;
  // count register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/sha_round_sequencer.sv
// sha_round_sequencer: per-job FSM stepping SHA rounds, tracking nonces and reporting hits
module sha_round_sequencer
  import sha_pkg::*;
#(
  parameter logic [31:0] NCORE = 32'd1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic        abort,
  input  logic [31:0] nonce_in,
  input  logic        hit,
  output logic [5:0]  cycle,
  output logic        round_en,
  output logic        load_block,
  output logic        clear_counter,
  output logic        hash_valid,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        found,
  output logic [31:0] win_nonce
);
  localparam logic [31:0] RANGE = range_for(NCORE);
  state_e      state_q, state_d;
  logic [5:0]  cycle_q, cycle_d;
  logic        found_q, found_d;
  logic [31:0] win_q, win_d, tried_q, tried_d, hash_cnt;
  logic        last_hash, to_done;
  counter #(.W(32)) u_hash_cnt (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (state_q == IDLE),
    .en          (state_q == CHECK),
    .rollover_val(RANGE),
    .count       (hash_cnt)
  );
  assign last_hash = hash_cnt + 32'd1 == RANGE;
  assign to_done   = state_q == CHECK && state_d == DONE;
  // next state: abort dominates every busy state, hit beats exhaustion in CHECK
  always_comb begin
    state_d = (state_q != IDLE && abort) ? IDLE :
              state_q == IDLE  ? (job_valid ? LOAD : IDLE) :
              state_q == LOAD  ? ROUND :
              state_q == ROUND ? (cycle_q == LAST_ROUND ? CHECK : ROUND) :
              state_q == CHECK ? ((hit || last_hash) ? DONE : LOAD) :
              result_ready     ? IDLE : DONE;
    cycle_d = (state_q == ROUND && state_d == ROUND) ? cycle_q + 6'd1 : 6'd0;
    tried_d = state_q == LOAD ? nonce_in : tried_q;
    found_d = to_done ? hit : found_q;
    win_d   = (to_done && hit) ? tried_q : win_q;
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      cycle_q <= 6'd0;
      found_q <= 1'b0;
      win_q   <= 32'd0;
      tried_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      found_q <= found_d;
      win_q   <= win_d;
      tried_q <= tried_d;
    end
  assign job_ready     = state_q == IDLE;
  assign clear_counter = state_q != IDLE;
  assign load_block    = state_q == LOAD;
  assign round_en      = state_q == ROUND;
  assign hash_valid    = state_q == CHECK;
  assign result_valid  = state_q == DONE;
  assign cycle         = cycle_q;
  assign found         = found_q;
  assign win_nonce     = win_q;
endmodule

// File: tb/tb_sha_round_sequencer.sv
// tb_sha_round_sequencer: directed scenario tests for the round sequencer (RANGE = 3)
module tb_sha_round_sequencer;
  logic        clk = 1'b0, n_rst = 1'b1, job_valid = 1'b0, abort = 1'b0, hit = 1'b0, result_ready = 1'b0;
  logic [31:0] nonce_in = 32'd0;
  logic        job_ready, round_en, load_block, clear_counter, hash_valid, result_valid, found;
  logic [5:0]  cycle;
  logic [31:0] win_nonce;
  int total = 0, bad = 0;
  localparam logic [44:0] RST_V = {1'b1, 6'b0, 6'd0, 32'd0};

  always #5 clk = ~clk;

  sha_round_sequencer #(.NCORE(32'h4000_0000)) dut (
    .clk(clk), .n_rst(n_rst), .job_valid(job_valid), .job_ready(job_ready), .abort(abort),
    .nonce_in(nonce_in), .hit(hit), .cycle(cycle), .round_en(round_en), .load_block(load_block),
    .clear_counter(clear_counter), .hash_valid(hash_valid), .result_valid(result_valid),
    .result_ready(result_ready), .found(found), .win_nonce(win_nonce)
  );

  function automatic logic [44:0] outs();
    return {job_ready, round_en, load_block, clear_counter, hash_valid, result_valid, found, cycle, win_nonce};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    job_valid = 1'b1;
    tick(1);
    job_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 n_rst = 1'b0;
    tick(2);
    total++; if (outs() !== RST_V) begin bad++; $display("FAIL reset_values: got %h want %h", outs(), RST_V); end
    n_rst = 1'b1;
    tick(1);
    total++; if ({job_ready, clear_counter} !== 2'b10) begin bad++; $display("FAIL idle_hold: got %b want 10", {job_ready, clear_counter}); end
  endtask

  task automatic test_hit();
    nonce_in = 32'd100;
    start_job();
    total++; if (outs() !== {7'b0011000, 6'd0, 32'd0}) begin bad++; $display("FAIL load_state: got %h want %h", outs(), {7'b0011000, 6'd0, 32'd0}); end
    tick(65);
    total++; if ({hash_valid, round_en, cycle} !== 8'b10_000000) begin bad++; $display("FAIL first_check_t66: got %b want 10000000", {hash_valid, round_en, cycle}); end
    nonce_in = 32'd101;
    tick(1);
    total++; if (load_block !== 1'b1) begin bad++; $display("FAIL second_load: got %b want 1", load_block); end
    tick(64);
    total++; if ({round_en, cycle} !== {1'b1, 6'd63}) begin bad++; $display("FAIL last_round: got %b want 1111111", {round_en, cycle}); end
    hit = 1'b1;
    tick(1);
    total++; if ({hash_valid, cycle} !== 7'b1_000000) begin bad++; $display("FAIL second_check: got %b want 1000000", {hash_valid, cycle}); end
    tick(1);
    hit = 1'b0;
    total++; if ({result_valid, found, win_nonce} !== {2'b11, 32'd101}) begin bad++; $display("FAIL hit_result_t133: got %h want %h", {result_valid, found, win_nonce}, {2'b11, 32'd101}); end
    tick(3);
    total++; if ({result_valid, found, win_nonce} !== {2'b11, 32'd101}) begin bad++; $display("FAIL result_hold: got %h want %h", {result_valid, found, win_nonce}, {2'b11, 32'd101}); end
    result_ready = 1'b1;
    tick(1);
    result_ready = 1'b0;
    total++; if ({result_valid, job_ready} !== 2'b01) begin bad++; $display("FAIL result_consume: got %b want 01", {result_valid, job_ready}); end
  endtask

  task automatic test_async_reset();
    nonce_in = 32'd5;
    start_job();
    tick(21);
    total++; if (cycle !== 6'd20) begin bad++; $display("FAIL pre_reset_cycle: got %0d want 20", cycle); end
    #2 n_rst = 1'b0;
    #1;
    total++; if (outs() !== RST_V) begin bad++; $display("FAIL async_reset: got %h want %h", outs(), RST_V); end
    tick(1);
    n_rst = 1'b1;
    tick(1);
    start_job();
    total++; if ({load_block, clear_counter, job_ready} !== 3'b110) begin bad++; $display("FAIL restart_load: got %b want 110", {load_block, clear_counter, job_ready}); end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    total++; if ({job_ready, load_block, round_en} !== 3'b100) begin bad++; $display("FAIL abort_in_load: got %b want 100", {job_ready, load_block, round_en}); end
  endtask

  task automatic test_cycle_exhaust();
    int p, n63 = 0, nhv = 0;
    logic [12:0] exp;
    nonce_in = 32'd0;
    start_job();
    job_valid = 1'b1;
    for (int t = 1; t <= 198; t++) begin
      p = (t - 1) % 66;
      exp = {1'b0, p >= 1 && p <= 64, p == 0, 1'b1, p == 65, 2'b00, (p >= 1 && p <= 64) ? 6'(p - 1) : 6'd0};
      total++; if (outs() >> 32 !== 45'(exp)) begin bad++; $display("FAIL seq_t%0d: got %b want %b", t, outs() >> 32, exp); end
      n63 += (cycle == 6'd63) ? 1 : 0;
      nhv += hash_valid ? 1 : 0;
      hit = p != 65;
      tick(1);
    end
    hit = 1'b0;
    job_valid = 1'b0;
    total++; if (n63 !== 3) begin bad++; $display("FAIL cycle63_count: got %0d want 3", n63); end
    total++; if (nhv !== 3) begin bad++; $display("FAIL hash_valid_count: got %0d want 3", nhv); end
    total++; if ({result_valid, found, win_nonce} !== {2'b10, 32'd0}) begin bad++; $display("FAIL exhausted: got %h want %h", {result_valid, found, win_nonce}, {2'b10, 32'd0}); end
    result_ready = 1'b1;
    tick(1);
    result_ready = 1'b0;
    total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL exhaust_to_idle: got %b want 1", job_ready); end
  endtask

  task automatic test_abort_round();
    int seen = 0;
    start_job();
    tick(41);
    total++; if (cycle !== 6'd40) begin bad++; $display("FAIL abort_cycle40: got %0d want 40", cycle); end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    total++; if ({job_ready, round_en, clear_counter, cycle} !== 9'b100_000000) begin bad++; $display("FAIL abort_in_round: got %b want 100000000", {job_ready, round_en, clear_counter, cycle}); end
    for (int i = 0; i < 70; i++) begin
      seen += (hash_valid || result_valid || !job_ready) ? 1 : 0;
      tick(1);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_quiet: got %0d want 0", seen); end
  endtask

  task automatic test_abort_hit();
    nonce_in = 32'd9;
    start_job();
    tick(65);
    total++; if (hash_valid !== 1'b1) begin bad++; $display("FAIL abort_hit_check: got %b want 1", hash_valid); end
    abort = 1'b1;
    hit = 1'b1;
    tick(1);
    abort = 1'b0;
    hit = 1'b0;
    total++; if ({job_ready, result_valid, hash_valid, load_block} !== 4'b1000) begin bad++; $display("FAIL abort_beats_hit: got %b want 1000", {job_ready, result_valid, hash_valid, load_block}); end
    tick(2);
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL abort_no_result: got %b want 0", result_valid); end
    nonce_in = 32'd7;
    start_job();
    tick(197);
    total++; if (hash_valid !== 1'b1) begin bad++; $display("FAIL final_check_t198: got %b want 1", hash_valid); end
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    total++; if ({result_valid, found, win_nonce} !== {2'b11, 32'd7}) begin bad++; $display("FAIL hit_on_last: got %h want %h", {result_valid, found, win_nonce}, {2'b11, 32'd7}); end
    result_ready = 1'b1;
    tick(1);
    result_ready = 1'b0;
    total++; if ({job_ready, result_valid} !== 2'b10) begin bad++; $display("FAIL final_idle: got %b want 10", {job_ready, result_valid}); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_async_reset();
    test_cycle_exhaust();
    test_abort_round();
    test_abort_hit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
